// File: rtl/les_stim_pkg.sv
// Shared types and helpers for the power-characterisation stimulus sequencer.
package les_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_SHIFT,
    ST_LAUNCH,
    ST_ARM,
    ST_WAIT,
    ST_COLLECT,
    ST_GAP
  } stim_state_e;

  localparam logic [31:0] DEFAULT_SEED = 32'hACE1ACE1;
  localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;

  // Rotate the low w bits of v left by k; bits above w are returned as zero.
  function automatic logic [63:0] rotl(input logic [63:0] v, input int unsigned w,
                                       input int unsigned k);
    logic [63:0] mask;
    logic [63:0] r;
    int unsigned sh;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sh   = k % w;
    if (sh == 0) r = v;
    else         r = (v << sh) | ((v & mask) >> (w - sh));
    return r & mask;
  endfunction

endpackage

// File: rtl/les_lfsr.sv
// Fibonacci LFSR: shifts left, XOR-reduced tap feedback enters bit 0.
module les_lfsr #(
  parameter int unsigned        DATA_W = 32,
  parameter logic [DATA_W-1:0]  SEED   = DATA_W'(32'hACE1ACE1),
  parameter logic [DATA_W-1:0]  TAPS   = DATA_W'(32'h80200003)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              shift_en,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn)       q <= SEED;
    else if (shift_en) q <= {q[DATA_W-2:0], ^(q & TAPS)};
  end

endmodule

// File: rtl/les_stim_sequencer.sv
// Workload sequencer: drives NUM_CH cipher cores through clear/advance/start/wait rounds
// and folds each round's results into a signature.
//
// state   | meaning
// IDLE    | parked, waiting for en
// CLR     | ch_clr pulse to all channels
// SHIFT   | stimulus LFSR advances one step
// LAUNCH  | ch_start pulse, plaintext stable
// ARM     | busy ignored while cores react to start; wait timer loaded
// WAIT    | wait for all busy low, or abort on timeout
// COLLECT | fold cipher outputs into signature, count round
// GAP     | GAP_CYCLES idle cycles; en/single sampled at the end
module les_stim_sequencer
  import les_stim_pkg::*;
#(
  parameter int unsigned       DATA_W     = 32,
  parameter logic [DATA_W-1:0] LFSR_SEED  = DATA_W'(DEFAULT_SEED),
  parameter logic [DATA_W-1:0] LFSR_TAPS  = DATA_W'(DEFAULT_TAPS),
  parameter int unsigned       NUM_CH     = 2,
  parameter int unsigned       GAP_CYCLES = 4,
  parameter int unsigned       TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       en,
  input  logic                       single,
  output logic [NUM_CH-1:0]          ch_clr,
  output logic [NUM_CH-1:0]          ch_start,
  output logic [NUM_CH*DATA_W-1:0]   ch_plaintext,
  input  logic [NUM_CH-1:0]          ch_busy,
  input  logic [NUM_CH*DATA_W-1:0]   ch_cipher,
  output logic [DATA_W-1:0]          signature,
  output logic [15:0]                round_cnt,
  output logic                       timeout_err,
  output logic                       active
);

  stim_state_e       state, state_nxt;
  logic [15:0]       wait_cnt;
  logic [15:0]       gap_cnt;
  logic [DATA_W-1:0] lfsr_q;
  logic [DATA_W-1:0] cipher_fold;
  logic              timeout_hit;

  // Advancing on entry to SHIFT means the new plaintext is already settled during SHIFT.
  les_lfsr #(
    .DATA_W (DATA_W),
    .SEED   (LFSR_SEED),
    .TAPS   (LFSR_TAPS)
  ) u_lfsr (
    .clk      (clk),
    .resetn   (resetn),
    .shift_en (state_nxt == ST_SHIFT),
    .q        (lfsr_q)
  );

  for (genvar k = 0; k < NUM_CH; k++) begin : g_pt
    assign ch_plaintext[k*DATA_W +: DATA_W] = DATA_W'(rotl(64'(lfsr_q), DATA_W, k));
  end

  always_comb begin
    cipher_fold = '0;
    for (int k = 0; k < NUM_CH; k++) cipher_fold = cipher_fold ^ ch_cipher[k*DATA_W +: DATA_W];
  end

  assign timeout_hit = (state == ST_WAIT) && (ch_busy != '0) && (wait_cnt == '0);

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (en) state_nxt = ST_CLR;
      ST_CLR:     state_nxt = ST_SHIFT;
      ST_SHIFT:   state_nxt = ST_LAUNCH;
      ST_LAUNCH:  state_nxt = ST_ARM;
      ST_ARM:     state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (ch_busy == '0)    state_nxt = ST_COLLECT;
        else if (timeout_hit) state_nxt = ST_GAP;
      end
      ST_COLLECT: state_nxt = ST_GAP;
      ST_GAP:     if (gap_cnt == '0) state_nxt = (en && !single) ? ST_CLR : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with the state they belong to.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ch_clr      <= '0;
      ch_start    <= '0;
      active      <= 1'b0;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      signature   <= '0;
      round_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      ch_clr   <= {NUM_CH{state_nxt == ST_CLR}};
      ch_start <= {NUM_CH{state_nxt == ST_LAUNCH}};
      active   <= (state_nxt != ST_IDLE);

      if (state == ST_ARM)
        wait_cnt <= 16'(TIMEOUT - 1);
      else if (state == ST_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 16'd1;

      if (state_nxt == ST_GAP && state != ST_GAP)
        gap_cnt <= 16'(GAP_CYCLES - 1);
      else if (state == ST_GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - 16'd1;

      if (state == ST_COLLECT) begin
        signature <= DATA_W'(rotl(64'(signature), DATA_W, 1)) ^ cipher_fold;
        round_cnt <= round_cnt + 16'd1;
      end

      if (timeout_hit) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_les_stim_sequencer.sv
// Bench for les_stim_sequencer: default build plus a 16-bit single-channel build.
module tb_les_stim_sequencer;

  localparam int GAP1 = 4;
  localparam int TMO1 = 255;
  localparam logic [63:0] SEED1 = 64'hACE1ACE1;
  localparam logic [63:0] TAPS1 = 64'h80200003;
  localparam logic [63:0] SEED2 = 64'hACE1;
  localparam logic [63:0] TAPS2 = 64'hB400;
  localparam int NRND = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // default instance
  logic        resetn, en, single;
  logic [1:0]  ch_clr, ch_start, ch_busy, hold_busy;
  logic [63:0] ch_plaintext, ch_cipher;
  logic [31:0] signature;
  logic [15:0] round_cnt;
  logic        timeout_err, active;

  // narrow instance
  logic        resetn2, en2, single2;
  logic [0:0]  ch_clr2, ch_start2, ch_busy2;
  logic [15:0] ch_plaintext2, ch_cipher2;
  logic [15:0] signature2;
  logic [15:0] round_cnt2;
  logic        timeout_err2, active2;

  les_stim_sequencer dut (
    .clk(clk), .resetn(resetn), .en(en), .single(single),
    .ch_clr(ch_clr), .ch_start(ch_start), .ch_plaintext(ch_plaintext),
    .ch_busy(ch_busy), .ch_cipher(ch_cipher), .signature(signature),
    .round_cnt(round_cnt), .timeout_err(timeout_err), .active(active)
  );

  les_stim_sequencer #(
    .DATA_W(16), .LFSR_SEED(16'hACE1), .LFSR_TAPS(16'hB400),
    .NUM_CH(1), .GAP_CYCLES(1), .TIMEOUT(255)
  ) dut2 (
    .clk(clk), .resetn(resetn2), .en(en2), .single(single2),
    .ch_clr(ch_clr2), .ch_start(ch_start2), .ch_plaintext(ch_plaintext2),
    .ch_busy(ch_busy2), .ch_cipher(ch_cipher2), .signature(signature2),
    .round_cnt(round_cnt2), .timeout_err(timeout_err2), .active(active2)
  );

  // ---------------- reference arithmetic ----------------
  function automatic logic [63:0] m_mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] m_step(input logic [63:0] v, input int w, input logic [63:0] taps);
    logic fb;
    fb = ^(v & taps);
    return ((v << 1) | {63'd0, fb}) & m_mask(w);
  endfunction

  function automatic logic [63:0] m_rotl(input logic [63:0] v, input int w, input int k);
    logic [63:0] r;
    r = v;
    for (int i = 0; i < k; i++) r = ((r << 1) | {63'd0, r[w-1]}) & m_mask(w);
    return r;
  endfunction

  // ---------------- core models ----------------
  // Each core registers start, raises busy one cycle later for busy_len cycles,
  // and returns plaintext ^ key as its cipher.
  int          busy_len1 = 3;
  logic [31:0] key1 [2];
  int          cnt1 = 0;
  logic        pa1 = 0, pb1 = 0;
  initial begin key1[0] = '0; key1[1] = '0; ch_cipher = '0; ch_busy = '0; end

  always @(negedge clk) begin
    if (!resetn) begin
      cnt1 = 0; pa1 = 0; pb1 = 0;
    end else begin
      if (cnt1 > 0) cnt1--;
      if (pb1) begin
        cnt1 = busy_len1;
        ch_cipher[31:0]  = ch_plaintext[31:0]  ^ key1[0];
        ch_cipher[63:32] = ch_plaintext[63:32] ^ key1[1];
      end
      pb1 = pa1;
      pa1 = (ch_start != 0);
    end
    ch_busy = {2{cnt1 != 0}} | hold_busy;
  end

  int   cnt2 = 0;
  logic pa2 = 0, pb2 = 0;
  initial begin ch_cipher2 = '0; ch_busy2 = '0; end

  always @(negedge clk) begin
    if (!resetn2) begin
      cnt2 = 0; pa2 = 0; pb2 = 0;
    end else begin
      if (cnt2 > 0) cnt2--;
      if (pb2) begin
        cnt2 = 2;
        ch_cipher2 = ch_plaintext2;
      end
      pb2 = pa2;
      pa2 = (ch_start2 != 0);
    end
    ch_busy2 = {cnt2 != 0};
  end

  int clr_seen = 0;
  always @(negedge clk) if (ch_clr != 0) clr_seen++;

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expired(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  task automatic wait_start(input int which, input int limit, output int at, output logic ok);
    ok = 0; at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 1) ? (ch_start != 0) : (ch_start2 != 0)) begin ok = 1; at = cyc; return; end
    end
  endtask

  task automatic wait_idle(input int which, input int limit, output int at, output logic ok);
    ok = 0; at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 1) ? !active : !active2) begin ok = 1; at = cyc; return; end
    end
  endtask

  task automatic wait_cnt1(input logic [15:0] target, input int limit, output int at, output logic ok);
    ok = 0; at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (round_cnt == target) begin ok = 1; at = cyc; return; end
    end
  endtask

  task automatic wait_tmo1(input int limit, output int at, output logic ok);
    ok = 0; at = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (timeout_err) begin ok = 1; at = cyc; return; end
    end
  endtask

  task automatic do_reset1();
    resetn = 0;
    repeat (2) @(negedge clk);
    resetn = 1;
  endtask

  // golden rounds with identity cores, busy 3
  typedef struct {
    logic [31:0] pt0;
    logic [31:0] pt1;
    logic [31:0] sig;
    logic [15:0] cnt;
  } round_vec_t;
  round_vec_t vec [3];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, t3, s;
    logic ok;
    logic [63:0] m, msig, fold;
    int b, prev_b, prev_t, clr_base;

    vec[0] = '{32'h59C359C3, 32'hB386B386, 32'hEA45EA45, 16'd1};
    vec[1] = '{32'hB386B386, 32'h670D670D, 32'h00000000, 16'd2};
    vec[2] = '{32'h670D670C, 32'hCE1ACE18, 32'hA917A914, 16'd3};

    resetn = 0; en = 0; single = 0; hold_busy = '0;
    resetn2 = 0; en2 = 0; single2 = 0;
    repeat (3) @(negedge clk);

    // ---- reset state ----
    check("rst_clr", ch_clr, 0);
    check("rst_start", ch_start, 0);
    check("rst_active", active, 0);
    check("rst_sig", signature, 0);
    check("rst_cnt", round_cnt, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_pt", ch_plaintext, {32'h59C359C3, 32'hACE1ACE1});

    // ---- single round ----
    resetn = 1;
    clr_base = clr_seen;
    busy_len1 = 3; en = 1; single = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ch_clr != 0) begin ok = 1; t = cyc; end
    end
    if (!ok) expired("t1_clr");
    check("t1_clr_val", ch_clr, 2'b11);
    check("t1_clr_nostart", ch_start, 0);
    wait_start(1, 10, t2, ok);
    if (!ok) expired("t1_start");
    check("t1_clr_to_start", t2 - t, 2);
    check("t1_pt0", ch_plaintext[31:0], 32'h59C359C3);
    check("t1_pt1", ch_plaintext[63:32], 32'hB386B386);
    wait_cnt1(16'd1, 40, t, ok);
    if (!ok) expired("t1_cnt");
    check("t1_sig", signature, 32'hEA45EA45);
    wait_idle(1, 20, t3, ok);
    en = 0;
    if (!ok) expired("t1_idle");
    check("t1_active_drop", t3 - t, GAP1);
    repeat (20) @(negedge clk);
    check("t1_one_clr", clr_seen - clr_base, 1);
    check("t1_idle_active", active, 0);

    // ---- three rounds against golden table ----
    do_reset1();
    busy_len1 = 3; en = 1; single = 0;
    prev_t = 0;
    for (int r = 0; r < 3; r++) begin
      wait_start(1, 40, t, ok);
      if (!ok) begin expired("t2_start"); break; end
      check("t2_pt0", ch_plaintext[31:0], vec[r].pt0);
      check("t2_pt1", ch_plaintext[63:32], vec[r].pt1);
      if (r > 0) check("t2_interval", t - prev_t, GAP1 + 6 + 3);
      prev_t = t;
      if (r == 2) single = 1;
      wait_cnt1(vec[r].cnt, 40, t2, ok);
      if (!ok) expired("t2_cnt");
      check("t2_sig", signature, vec[r].sig);
    end
    wait_idle(1, 20, t, ok);
    en = 0;
    if (!ok) expired("t2_idle");
    check("t2_final_cnt", round_cnt, 3);

    // ---- timeout on a stuck channel ----
    do_reset1();
    hold_busy = 2'b10; busy_len1 = 3; en = 1; single = 0;
    wait_start(1, 20, s, ok);
    if (!ok) expired("t3_start");
    wait_tmo1(400, t, ok);
    if (!ok) expired("t3_tmo");
    check("t3_tmo_delay", t - s, TMO1 + 2);
    check("t3_cnt", round_cnt, 0);
    check("t3_sig", signature, 0);
    wait_start(1, 20, t2, ok);
    hold_busy = 2'b00; single = 1;
    if (!ok) expired("t3_restart");
    check("t3_restart_delay", t2 - t, GAP1 + 2);
    wait_cnt1(16'd1, 40, t3, ok);
    if (!ok) expired("t3_cnt_after");
    check("t3_sticky", timeout_err, 1);
    wait_idle(1, 20, t, ok);
    en = 0;
    if (!ok) expired("t3_idle");

    // ---- en dropped during WAIT ----
    do_reset1();
    clr_base = clr_seen;
    busy_len1 = 5; en = 1; single = 0;
    wait_start(1, 20, t, ok);
    if (!ok) expired("t4_start");
    repeat (3) @(negedge clk);
    en = 0;
    wait_cnt1(16'd1, 40, t, ok);
    if (!ok) expired("t4_cnt");
    wait_idle(1, 20, t, ok);
    if (!ok) expired("t4_idle");
    repeat (30) @(negedge clk);
    check("t4_cnt", round_cnt, 1);
    check("t4_one_clr", clr_seen - clr_base, 1);
    check("t4_active", active, 0);

    // ---- reset during WAIT of the second round ----
    do_reset1();
    busy_len1 = 5; en = 1; single = 0;
    wait_cnt1(16'd1, 60, t, ok);
    if (!ok) expired("t5_cnt");
    wait_start(1, 30, t, ok);
    if (!ok) expired("t5_start");
    repeat (3) @(negedge clk);
    resetn = 0;
    @(negedge clk);
    check("t5_clr", ch_clr, 0);
    check("t5_start", ch_start, 0);
    check("t5_active", active, 0);
    check("t5_sig", signature, 0);
    check("t5_cnt", round_cnt, 0);
    check("t5_tmo", timeout_err, 0);
    check("t5_lfsr", ch_plaintext[31:0], 32'hACE1ACE1);
    resetn = 1;
    wait_start(1, 20, t, ok);
    single = 1;
    if (!ok) expired("t5_restart");
    check("t5_pt_again", ch_plaintext[31:0], 32'h59C359C3);
    wait_idle(1, 60, t, ok);
    en = 0;
    if (!ok) expired("t5_idle");

    // ---- randomized rounds vs reference model ----
    do_reset1();
    en = 1; single = 0;
    m = SEED1; msig = '0; prev_b = 0; prev_t = 0;
    for (int r = 0; r < NRND; r++) begin
      wait_start(1, 60, t, ok);
      if (!ok) begin expired("rnd_start"); break; end
      m = m_step(m, 32, TAPS1);
      check("rnd_pt0", ch_plaintext[31:0], m);
      check("rnd_pt1", ch_plaintext[63:32], m_rotl(m, 32, 1));
      if (r > 0) check("rnd_interval", t - prev_t, GAP1 + 6 + prev_b);
      b = $urandom_range(1, 8);
      busy_len1 = b;
      key1[0] = $urandom;
      key1[1] = $urandom;
      fold = (m ^ {32'd0, key1[0]}) ^ (m_rotl(m, 32, 1) ^ {32'd0, key1[1]});
      msig = m_rotl(msig, 32, 1) ^ fold;
      prev_b = b; prev_t = t;
      if (r == NRND - 1) single = 1;
    end
    wait_idle(1, 100, t, ok);
    en = 0;
    if (!ok) expired("rnd_idle");
    check("rnd_sig", signature, msig);
    check("rnd_cnt", round_cnt, NRND);
    check("rnd_no_tmo", timeout_err, 0);

    // ---- narrow build: 16-bit LFSR, one channel, gap 1, counter wrap ----
    repeat (2) @(negedge clk);
    resetn2 = 1;
    @(negedge clk);
    check("d2_reset_pt", ch_plaintext2, 16'hACE1);
    force dut2.round_cnt = 16'hFFFE;
    @(negedge clk);
    release dut2.round_cnt;
    @(negedge clk);
    check("d2_forced_cnt", round_cnt2, 16'hFFFE);
    m = SEED2; msig = '0; prev_t = 0;
    en2 = 1;
    for (int r = 0; r < 4; r++) begin
      wait_start(2, 30, t, ok);
      if (!ok) begin expired("d2_start"); break; end
      m = m_step(m, 16, TAPS2);
      check("d2_pt", ch_plaintext2, m);
      if (r > 0) check("d2_interval", t - prev_t, 1 + 6 + 2);
      check("d2_cnt_wrap", round_cnt2, 64'(16'(32'hFFFE + r)));
      msig = m_rotl(msig, 16, 1) ^ m;
      prev_t = t;
      if (r == 3) single2 = 1;
    end
    wait_idle(2, 40, t, ok);
    en2 = 0;
    if (!ok) expired("d2_idle");
    check("d2_sig", signature2, msig);
    check("d2_final_cnt", round_cnt2, 16'h0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/les_stim_sequencer.md
Name: les_stim_sequencer

Overview:
Parametrised workload sequencer for the power-characterisation builds. It owns the stimulus LFSR and drives NUM_CH cipher cores through repeated clear -> advance -> start -> wait-for-done rounds. Rounds are paced by the cores' busy handshake, not by a fixed counter schedule. Each round's cipher outputs are folded into a signature so the work cannot be optimised away. A round counter and a sticky timeout flag feed the LEDs.

Parameters:
DATA_W, 32, plaintext/cipher/LFSR width (>=8)
LFSR_SEED, 32'hACE1ACE1, LFSR reset/seed value (DATA_W bits, nonzero)
LFSR_TAPS, 32'h80200003, tap mask; feedback = XOR-reduce(lfsr & LFSR_TAPS)
NUM_CH, 2, number of cipher channels (1..8)
GAP_CYCLES, 4, idle cycles between rounds (>=1)
TIMEOUT, 255, max WAIT cycles before abort (1..65535)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
en  in  1  run enable, level-sensitive
single  in  1  1 = stop after the current round
ch_clr  out  NUM_CH  per-channel clear pulse
ch_start  out  NUM_CH  per-channel start pulse
ch_plaintext  out  NUM_CH*DATA_W  channel k slice = lfsr rotated left by k
ch_busy  in  NUM_CH  per-channel busy
ch_cipher  in  NUM_CH*DATA_W  per-channel cipher result
signature  out  DATA_W  folded result
round_cnt  out  16  completed rounds, wraps 0xFFFF -> 0
timeout_err  out  1  sticky abort flag
active  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: single clock `clk`. Reset is synchronous, active-low on `resetn`, sampled on the clk rising edge and overriding everything, including a round in progress.
- Reset values: state IDLE, lfsr=LFSR_SEED, signature=0, round_cnt=0, timeout_err=0. ch_clr, ch_start and active are 0. ch_plaintext reflects the seed.
- LFSR: Fibonacci, shifts left with the feedback bit into bit0. It advances only in the SHIFT state.
- IDLE: moves to CLR when en=1.
- CLR (1 cycle): ch_clr all-ones. Next state SHIFT.
- SHIFT (1 cycle): lfsr advances one step. Next state LAUNCH.
- LAUNCH (1 cycle): ch_start all-ones. ch_plaintext is already stable from the previous cycle and stays stable until the next SHIFT. Next state ARM.
- ARM (1 cycle): ch_busy is ignored, because cores raise busy one cycle after start. The wait counter is cleared. Next state WAIT.
- WAIT:
  - If ch_busy == 0 for all channels, go to COLLECT.
  - Otherwise increment the wait counter.
  - When the counter reaches TIMEOUT with any busy still high: set timeout_err, go to GAP, skip COLLECT.
- COLLECT (1 cycle): signature <= rotl1(signature) ^ (XOR of all ch_cipher slices). round_cnt++. Next state GAP.
- GAP: lasts exactly GAP_CYCLES cycles. Then:
  - if en=1 and single=0, go to CLR;
  - otherwise go to IDLE.
- en or single changes mid-round: the current round always completes, including GAP. The inputs are sampled only at the end of GAP and in IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Minimum round length is 6 + GAP_CYCLES + busy time.
- timeout_err clears only on reset.

Decomposition:
- Package les_stim_pkg:
  - state enum (IDLE, CLR, SHIFT, LAUNCH, ARM, WAIT, COLLECT, GAP);
  - default seed and tap constants;
  - rotl function.
- Sub-module les_lfsr:
  - parameters DATA_W, SEED, TAPS;
  - ports clk, resetn, shift_en, q.
- Sequencer FSM, wait/gap counters and signature logic stay in les_stim_sequencer.

Test Plan:
1. Reset, en=1, single=1, NUM_CH=2, cores modelled as identity with busy high for 3 cycles -> one ch_clr pulse, then ch_start. ch_plaintext ch0=0x59C359C3, ch1=0xB386B386. signature=0xEA45EA45, round_cnt=1. active drops GAP_CYCLES cycles after COLLECT.
2. en=1, single=0, same cores for 3 rounds -> round_cnt=3. The LFSR step sequence starts 0x59C359C3 and each ch_start is GAP_CYCLES+6+3 cycles after the previous one. signature matches the golden model.
3. ch_busy[1] held high, TIMEOUT=255 -> timeout_err rises after 255 WAIT cycles. round_cnt=0 and signature=0. The next round still starts after GAP.
4. en dropped during WAIT -> round completes with round_cnt incremented, then IDLE with no further ch_clr.
5. resetn low during WAIT -> next cycle all outputs at reset values and lfsr=0xACE1ACE1. The following round again produces 0x59C359C3.
6. NUM_CH=1, GAP_CYCLES=1, DATA_W=16, SEED=16'hACE1, TAPS=16'hB400 -> plaintext sequence matches the reference LFSR model. round_cnt forced near 0xFFFF wraps to 0.
